// File: rtl/traffic_stat_mem_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types and helpers for the hourly traffic statistics memory.
//   dump_state_t  : table-dump FSM states
//   SLOTS_PER_DAY : default depth of the hourly table
//   sat_add       : unsigned add clamped to an arbitrary width (<= 32 bits)
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam int SLOTS_PER_DAY = 24;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        PRESENT,
        DONE
    } dump_state_t;

    // Operands are zero-extended to 32 bits by the caller; the result is
    // clamped to 2**width-1 and the caller narrows it back to width bits.
    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input int unsigned width);
        logic [32:0] s;
        logic [32:0] mx;
        s  = {1'b0, a} + {1'b0, b};
        mx = (33'd1 << width) - 33'd1;
        if (s > mx) begin
            return mx[31:0];
        end
        return s[31:0];
    endfunction

endpackage

// File: rtl/traffic_stat_mem_if.sv
// ---------------------------------------------------------------------------
// traffic_stat_mem_if
// Table-dump request and entry stream between the statistics memory
// (master) and the rank calculator (slave).
//   DUMP_REQ  : request a full-table stream
//   DUMP_BUSY : dump in progress
//   RD_VALID / RD_READY : entry handshake
//   RD_SLOT / RD_DATA   : slot index and value of the presented entry
//   DUMP_DONE : one-cycle pulse after the last entry is accepted
// ---------------------------------------------------------------------------
interface traffic_stat_mem_if #(
    parameter int HOUR_W = 5,
    parameter int ACC_W  = 15
);
    logic              DUMP_REQ;
    logic              DUMP_BUSY;
    logic              RD_VALID;
    logic              RD_READY;
    logic [HOUR_W-1:0] RD_SLOT;
    logic [ACC_W-1:0]  RD_DATA;
    logic              DUMP_DONE;

    modport master (
        input  DUMP_REQ,
        input  RD_READY,
        output DUMP_BUSY,
        output RD_VALID,
        output RD_SLOT,
        output RD_DATA,
        output DUMP_DONE
    );

    modport slave (
        output DUMP_REQ,
        output RD_READY,
        input  DUMP_BUSY,
        input  RD_VALID,
        input  RD_SLOT,
        input  RD_DATA,
        input  DUMP_DONE
    );
endinterface

// File: rtl/traffic_stat_mem_sum_sat.sv
// ---------------------------------------------------------------------------
// traffic_sum_sat
// Combinational per-sample channel adder and saturating accumulate.
//   sample_cnt : NUM_CH packed CNT_W amounts, channel 0 in the LSBs
//   accum      : current accumulator value
//   accum_next : sat(accum + sum of channels)
//   seed       : sat(sum of channels), used to start a fresh hour
// ---------------------------------------------------------------------------
module traffic_sum_sat
    import traffic_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 3,
    parameter int ACC_W  = 15
) (
    input  logic [NUM_CH*CNT_W-1:0] sample_cnt,
    input  logic [ACC_W-1:0]        accum,
    output logic [ACC_W-1:0]        accum_next,
    output logic [ACC_W-1:0]        seed
);

    localparam int SUM_W = CNT_W + $clog2(NUM_CH);

    logic [SUM_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            sum = sum + SUM_W'(sample_cnt[ch*CNT_W +: CNT_W]);
        end
    end

    assign accum_next = ACC_W'(sat_add(32'(accum), 32'(sum), ACC_W));
    assign seed       = ACC_W'(sat_add(32'd0, 32'(sum), ACC_W));

endmodule

// File: rtl/traffic_stat_mem.sv
// ---------------------------------------------------------------------------
// traffic_stat_mem
// Accumulates per-sample car counts of NUM_CH channels into a live hourly
// accumulator, commits it into a SLOTS-deep table on every hour change and
// streams the whole table out on request, one entry per two cycles.
//   CLK, RESET   : clock, synchronous active-high reset
//   HOUR         : current hour from the clock block
//   SAMPLE_VALID / SAMPLE_CNT : traffic sample input
//   LIVE_ACCUM   : current-hour accumulator
//   dump         : request / entry stream (traffic_stat_mem_if.master)
//   PEAK_SLOT / PEAK_DATA : largest committed value and its slot
// Build option: define PEAK_TRACK_EN to build the peak tracker; otherwise
// the peak outputs are tied to 0.
// ---------------------------------------------------------------------------
module traffic_stat_mem
    import traffic_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 3,
    parameter int ACC_W  = 15,
    parameter int SLOTS  = SLOTS_PER_DAY,
    parameter int HOUR_W = 5
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [HOUR_W-1:0]       HOUR,
    input  logic                    SAMPLE_VALID,
    input  logic [NUM_CH*CNT_W-1:0] SAMPLE_CNT,
    output logic [ACC_W-1:0]        LIVE_ACCUM,
    traffic_stat_mem_if.master      dump,
    output logic [HOUR_W-1:0]       PEAK_SLOT,
    output logic [ACC_W-1:0]        PEAK_DATA
);

    localparam logic [HOUR_W-1:0] LAST_IDX = HOUR_W'(SLOTS - 1);

    logic [ACC_W-1:0]  accum;
    logic [ACC_W-1:0]  accum_next;
    logic [ACC_W-1:0]  seed;
    logic [HOUR_W-1:0] hour_q;
    logic [ACC_W-1:0]  tbl [SLOTS];
    logic              hour_chg;
    logic              commit_en;

    dump_state_t       state_q;
    dump_state_t       state_d;
    logic [HOUR_W-1:0] idx_q;
    logic              rd_valid_q;
    logic [HOUR_W-1:0] rd_slot_q;
    logic [ACC_W-1:0]  rd_data_q;
    logic [ACC_W-1:0]  load_val;

    traffic_sum_sat #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W)
    ) u_sum (
        .sample_cnt (SAMPLE_CNT),
        .accum      (accum),
        .accum_next (accum_next),
        .seed       (seed)
    );

    // Hours outside the table still restart the accumulator but never write.
    assign hour_chg  = (HOUR != hour_q);
    assign commit_en = hour_chg && (32'(hour_q) < 32'(SLOTS));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            accum  <= '0;
            hour_q <= HOUR;
        end else if (hour_chg) begin
            accum  <= SAMPLE_VALID ? seed : '0;
            hour_q <= HOUR;
        end else if (SAMPLE_VALID) begin
            accum  <= accum_next;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < SLOTS; i++) begin
                tbl[i] <= '0;
            end
        end else if (commit_en) begin
            tbl[hour_q] <= accum;
        end
    end

    assign LIVE_ACCUM = accum;

    // A commit landing on the slot being loaded is forwarded so the stream
    // never shows the stale pre-commit value.
    assign load_val = (commit_en && (hour_q == idx_q)) ? accum : tbl[idx_q];

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (dump.DUMP_REQ) state_d = LOAD;
            LOAD:    state_d = PRESENT;
            PRESENT: begin
                if (rd_valid_q && dump.RD_READY) begin
                    state_d = (idx_q == LAST_IDX) ? DONE : LOAD;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Presented entry registers only change in LOAD, so they hold under
    // backpressure regardless of table writes.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q      <= '0;
            rd_valid_q <= 1'b0;
            rd_slot_q  <= '0;
            rd_data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (dump.DUMP_REQ) idx_q <= '0;
                end
                LOAD: begin
                    rd_slot_q  <= idx_q;
                    rd_data_q  <= load_val;
                    rd_valid_q <= 1'b1;
                end
                PRESENT: begin
                    if (rd_valid_q && dump.RD_READY) begin
                        rd_valid_q <= 1'b0;
                        if (idx_q != LAST_IDX) idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dump.RD_VALID  = rd_valid_q;
    assign dump.RD_SLOT   = rd_slot_q;
    assign dump.RD_DATA   = rd_data_q;
    assign dump.DUMP_BUSY = (state_q != IDLE);
    assign dump.DUMP_DONE = (state_q == DONE);

`ifdef PEAK_TRACK_EN
    logic [HOUR_W-1:0] peak_slot_q;
    logic [ACC_W-1:0]  peak_data_q;

    // Strict compare keeps the earliest slot on ties.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            peak_slot_q <= '0;
            peak_data_q <= '0;
        end else if (commit_en && (accum > peak_data_q)) begin
            peak_slot_q <= hour_q;
            peak_data_q <= accum;
        end
    end

    assign PEAK_SLOT = peak_slot_q;
    assign PEAK_DATA = peak_data_q;
`else
    assign PEAK_SLOT = '0;
    assign PEAK_DATA = '0;
`endif

endmodule

// File: tb/tb_traffic_stat_mem.sv
// ---------------------------------------------------------------------------
// tb_traffic_stat_mem
// Self-checking bench for traffic_stat_mem: directed scenarios plus random
// traffic, an arithmetic reference model of the hourly table, and a
// scoreboard monitor that checks every streamed table entry.
// ---------------------------------------------------------------------------
module tb_traffic_stat_mem;

    localparam int NUM_CH  = 2;
    localparam int CNT_W   = 3;
    localparam int ACC_W   = 15;
    localparam int SLOTS   = 24;
    localparam int HOUR_W  = 5;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
`ifdef PEAK_TRACK_EN
    localparam bit PEAK_ON = 1'b1;
`else
    localparam bit PEAK_ON = 1'b0;
`endif

    logic                    CLK = 1'b0;
    logic                    RESET;
    logic [HOUR_W-1:0]       HOUR;
    logic                    SAMPLE_VALID;
    logic [NUM_CH*CNT_W-1:0] SAMPLE_CNT;
    logic [ACC_W-1:0]        LIVE_ACCUM;
    logic [HOUR_W-1:0]       PEAK_SLOT;
    logic [ACC_W-1:0]        PEAK_DATA;

    always #5 CLK = ~CLK;

    traffic_stat_mem_if #(.HOUR_W(HOUR_W), .ACC_W(ACC_W)) dif ();

    traffic_stat_mem #(
        .NUM_CH (NUM_CH),
        .CNT_W  (CNT_W),
        .ACC_W  (ACC_W),
        .SLOTS  (SLOTS),
        .HOUR_W (HOUR_W)
    ) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .HOUR         (HOUR),
        .SAMPLE_VALID (SAMPLE_VALID),
        .SAMPLE_CNT   (SAMPLE_CNT),
        .LIVE_ACCUM   (LIVE_ACCUM),
        .dump         (dif.master),
        .PEAK_SLOT    (PEAK_SLOT),
        .PEAK_DATA    (PEAK_DATA)
    );

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int exp_slot_q[$];
    int exp_data_q[$];

    // Reference model state
    int mtbl [SLOTS];
    int macc;
    int mhour;
    int mpeak_slot;
    int mpeak_data;

    function automatic void chk(string nm, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endfunction

    function automatic int sample_sum();
        int s = 0;
        for (int c = 0; c < NUM_CH; c++) s += int'(SAMPLE_CNT[c*CNT_W +: CNT_W]);
        return s;
    endfunction

    // One clock of the spec's rules, evaluated on the inputs present now.
    function automatic void model_update();
        if (RESET) begin
            foreach (mtbl[i]) mtbl[i] = 0;
            macc = 0;
            mhour = int'(HOUR);
            mpeak_slot = 0;
            mpeak_data = 0;
        end else if (int'(HOUR) != mhour) begin
            if (mhour < SLOTS) begin
                mtbl[mhour] = macc;
                if (macc > mpeak_data) begin
                    mpeak_data = macc;
                    mpeak_slot = mhour;
                end
            end
            macc = SAMPLE_VALID ? sample_sum() : 0;
            mhour = int'(HOUR);
        end else if (SAMPLE_VALID) begin
            macc = macc + sample_sum();
            if (macc > ACC_MAX) macc = ACC_MAX;
        end
    endfunction

    task automatic step();
        model_update();
        @(posedge CLK);
        #1;
        chk("live_accum", int'(LIVE_ACCUM), macc);
        chk("peak_slot", int'(PEAK_SLOT), PEAK_ON ? mpeak_slot : 0);
        chk("peak_data", int'(PEAK_DATA), PEAK_ON ? mpeak_data : 0);
    endtask

    // Scoreboard monitor: checks every accepted entry and entry stability
    // while the consumer stalls.
    logic held = 1'b0;
    int   h_slot, h_data;

    always @(negedge CLK) begin
        if (RESET) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                chk("hold_valid", int'(dif.RD_VALID), 1);
                chk("hold_slot", int'(dif.RD_SLOT), h_slot);
                chk("hold_data", int'(dif.RD_DATA), h_data);
            end
            if (dif.RD_VALID && !dif.RD_READY) begin
                held   <= 1'b1;
                h_slot  = int'(dif.RD_SLOT);
                h_data  = int'(dif.RD_DATA);
            end else begin
                held <= 1'b0;
            end
            if (dif.RD_VALID && dif.RD_READY) begin
                if (exp_slot_q.size() == 0) begin
                    chk("unexpected_entry", int'(dif.RD_SLOT), -1);
                end else begin
                    chk("rd_slot", int'(dif.RD_SLOT), exp_slot_q.pop_front());
                    chk("rd_data", int'(dif.RD_DATA), exp_data_q.pop_front());
                end
            end
            if (dif.DUMP_DONE) done_cnt++;
        end
    end

    task automatic do_reset(input int hr);
        RESET = 1'b1;
        HOUR = HOUR_W'(hr);
        SAMPLE_VALID = 1'b0;
        dif.DUMP_REQ = 1'b0;
        dif.RD_READY = 1'b1;
        step();
        step();
        chk("rst_rd_valid", int'(dif.RD_VALID), 0);
        chk("rst_busy", int'(dif.DUMP_BUSY), 0);
        chk("rst_done", int'(dif.DUMP_DONE), 0);
        chk("rst_rd_slot", int'(dif.RD_SLOT), 0);
        chk("rst_rd_data", int'(dif.RD_DATA), 0);
        exp_slot_q.delete();
        exp_data_q.delete();
        RESET = 1'b0;
    endtask

    task automatic samples(input int n, input logic [NUM_CH*CNT_W-1:0] cnt);
        SAMPLE_VALID = 1'b1;
        SAMPLE_CNT = cnt;
        repeat (n) step();
        SAMPLE_VALID = 1'b0;
    endtask

    // mode 0: ready high, latency checked; 1: random ready;
    // 2: stall slot 0 for 5 cycles and commit into slot 0 meanwhile.
    task automatic do_dump(input int mode);
        int n, hold, prev_done;
        chk("busy_before_dump", int'(dif.DUMP_BUSY), 0);
        prev_done = done_cnt;
        dif.DUMP_REQ = 1'b1;
        dif.RD_READY = 1'b1;
        step();
        dif.DUMP_REQ = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            exp_slot_q.push_back(i);
            exp_data_q.push_back(mtbl[i]);
        end
        n = 1;
        hold = 0;
        while (!dif.DUMP_DONE && n < 3000) begin
            SAMPLE_VALID = 1'($urandom % 2);
            SAMPLE_CNT = 6'($urandom);
            if (mode != 0) dif.DUMP_REQ = 1'($urandom % 2);
            if (mode == 1) begin
                dif.RD_READY = 1'($urandom % 2);
            end else if (mode == 2 && dif.RD_VALID && dif.RD_SLOT == 0 && hold < 5) begin
                dif.RD_READY = 1'b0;
                hold++;
                if (hold == 2) HOUR = HOUR + 1'b1;
            end else begin
                dif.RD_READY = 1'b1;
            end
            step();
            n++;
        end
        chk("dump_done_seen", int'(dif.DUMP_DONE), 1);
        if (mode == 0) chk("dump_latency", n, 2*SLOTS + 1);
        if (mode == 2) chk("stall_cycles", hold, 5);
        dif.DUMP_REQ = 1'b0;
        dif.RD_READY = 1'b1;
        SAMPLE_VALID = 1'b0;
        step();
        chk("busy_after_done", int'(dif.DUMP_BUSY), 0);
        chk("done_one_cycle", int'(dif.DUMP_DONE), 0);
        step();
        chk("no_queued_dump", int'(dif.DUMP_BUSY), 0);
        chk("done_pulses", done_cnt, prev_done + 1);
        chk("queue_drained", exp_slot_q.size(), 0);
    endtask

    initial begin
        int n, prev_done;
        RESET = 1'b1;
        HOUR = '0;
        SAMPLE_VALID = 1'b0;
        SAMPLE_CNT = '0;
        dif.DUMP_REQ = 1'b0;
        dif.RD_READY = 1'b1;

        // Peak tracking: 40@1, 90@2, 90@5
        do_reset(1);
        samples(5, {3'd5, 3'd3});
        HOUR = 5'd2; step();
        samples(10, {3'd5, 3'd4});
        HOUR = 5'd5; step();
        samples(10, {3'd5, 3'd4});
        HOUR = 5'd6; step();
        chk("peak_slot_final", int'(PEAK_SLOT), PEAK_ON ? 2 : 0);
        chk("peak_data_final", int'(PEAK_DATA), PEAK_ON ? 90 : 0);

        // Accumulate 10 x 7 at hour 3, commit, dump immediately
        do_reset(3);
        samples(10, {3'd5, 3'd2});
        chk("live_70", int'(LIVE_ACCUM), 70);
        HOUR = 5'd4; step();
        chk("live_after_commit", int'(LIVE_ACCUM), 0);
        do_dump(0);

        // Hour change with a same-cycle sample of 6
        samples(3, {3'd1, 3'd2});
        HOUR = 5'd5;
        samples(1, {3'd3, 3'd3});
        chk("live_seeded", int'(LIVE_ACCUM), 6);

        // Saturation at 2**ACC_W-1
        samples(2340, {3'd7, 3'd7});
        chk("live_near_max", int'(LIVE_ACCUM), 32766);
        samples(1, {3'd7, 3'd7});
        chk("live_saturated", int'(LIVE_ACCUM), 32767);
        samples(3, {3'd7, 3'd7});
        chk("live_stays_max", int'(LIVE_ACCUM), 32767);
        HOUR = 5'd6; step();

        // Backpressure on slot 0 with a commit into slot 0 meanwhile
        HOUR = 5'd0; step();
        samples(4, {3'd2, 3'd1});
        do_dump(2);
        do_dump(0);

        // Reset in the middle of a dump
        dif.DUMP_REQ = 1'b1;
        step();
        dif.DUMP_REQ = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            exp_slot_q.push_back(i);
            exp_data_q.push_back(mtbl[i]);
        end
        n = 0;
        while (!(dif.RD_VALID && dif.RD_SLOT == 5'd10) && n < 200) begin
            step();
            n++;
        end
        chk("reached_slot10", int'(dif.RD_SLOT), 10);
        prev_done = done_cnt;
        RESET = 1'b1;
        HOUR = 5'd0;
        step();
        chk("midrst_rd_valid", int'(dif.RD_VALID), 0);
        chk("midrst_busy", int'(dif.DUMP_BUSY), 0);
        exp_slot_q.delete();
        exp_data_q.delete();
        RESET = 1'b0;
        repeat (60) step();
        chk("no_done_after_reset", done_cnt, prev_done);
        do_dump(1);

        // Out-of-table hour: commit suppressed
        HOUR = 5'd30; step();
        samples(5, {3'd7, 3'd7});
        HOUR = 5'd2; step();
        do_dump(1);

        // Random traffic and hour changes, then randomized-ready dumps
        for (int it = 0; it < 4; it++) begin
            for (int c = 0; c < 150; c++) begin
                SAMPLE_VALID = 1'($urandom % 2);
                SAMPLE_CNT = 6'($urandom);
                if ($urandom % 16 == 0) HOUR = 5'($urandom_range(0, 31));
                step();
            end
            SAMPLE_VALID = 1'b0;
            do_dump(1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
